// File: rtl/mc_control.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback
// and guards every memory wait with a timeout that drops into a sticky fault HALT.
module mc_control #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        Reg2Loc,
  output logic        ALUSrcA,
  output logic [1:0]  PCSrc,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        retire,
  output logic        fault,
  output logic [3:0]  state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_LD_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_CBZ      = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_HALT     = 4'd10;

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [3:0]    next_state;
  logic          next_fault;
  logic [CW-1:0] wait_cnt;
  logic          is_ldur, is_stur, is_rtype, is_cbz, is_b;
  logic          mem_wait_state, timed_out;

  assign is_ldur  = (opcode == 11'b11111000010);
  assign is_stur  = (opcode == 11'b11111000000);
  assign is_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                    (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
  assign is_cbz   = (opcode[10:3] == 8'b10110100);
  assign is_b     = (opcode[10:5] == 6'b000101);

  assign mem_wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // A ready arriving on the last allowed cycle still completes the access.
  assign timed_out = mem_wait_state && !mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    next_state = state;
    next_fault = fault;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        if (is_ldur || is_stur) next_state = S_MEM_ADDR;
        else if (is_rtype)      next_state = S_R_EXEC;
        else if (is_cbz)        next_state = S_CBZ;
        else if (is_b)          next_state = S_BRANCH;
        else begin
          next_state = S_HALT;
          next_fault = 1'b1;
        end
      end
      S_MEM_ADDR: begin
        if (is_ldur)      next_state = S_MEM_RD;
        else if (is_stur) next_state = S_MEM_WR;
        else begin
          next_state = S_HALT;
          next_fault = 1'b1;
        end
      end
      S_MEM_RD:   if (mem_ready) next_state = S_LD_WB;
      S_LD_WB:    next_state = S_FETCH;
      S_MEM_WR:   if (mem_ready) next_state = S_FETCH;
      S_R_EXEC:   next_state = S_R_WB;
      S_R_WB:     next_state = S_FETCH;
      S_CBZ:      next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_HALT:     next_state = S_HALT;
      default: begin
        next_state = S_HALT;
        next_fault = 1'b1;
      end
    endcase
    if (timed_out) begin
      next_state = S_HALT;
      next_fault = 1'b1;
    end
  end

  // The wait counter only runs while parked in a memory state; any move clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      fault <= next_fault;
      if (mem_wait_state && next_state == state) wait_cnt <= wait_cnt + 1'b1;
      else                                       wait_cnt <= '0;
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    MemtoReg = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrcA  = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    retire   = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Reg2Loc = is_stur || is_cbz;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_LD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
      end
      S_MEM_WR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_CBZ: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b10;
        PCWrite = zero;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
        retire  = 1'b1;
      end
      default: ;
    endcase
    // Nothing may commit while reset is held, whatever state we are leaving.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      retire   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: per-instruction state paths held in a queue drive a
// reference model compared every cycle, plus directed literal traces.
module tb_mc_control;

  localparam int TIMEOUT = 16;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3, S_LD_WB = 4;
  localparam int S_MEM_WR = 5, S_R_EXEC = 6, S_R_WB = 7, S_CBZ = 8, S_BRANCH = 9, S_HALT = 10;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] opcode = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, ALUSrcA;
  logic [1:0]  PCSrc, ALUSrcB, ALUOp;
  logic        retire, fault;
  logic [3:0]  state;

  int total = 0;
  int bad = 0;

  always #5 tb_clk = ~tb_clk;

  mc_control #(.TIMEOUT(TIMEOUT)) dut (
    .clk(tb_clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc),
    .ALUSrcA(ALUSrcA), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .retire(retire), .fault(fault), .state(state)
  );

  typedef struct packed {
    logic       pcw, irw, iord, mrd, mwr, rgw, m2r, r2l, asa;
    logic [1:0] pcsrc, asb, aluop;
    logic       retire, fault;
    logic [3:0] state;
  } obs_t;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Reference model: each instruction class is a list of states to walk through.
  int  m_state = S_FETCH;
  int  m_wait = 0;
  bit  m_fault = 1'b0;
  bit  m_valid = 1'b0;
  int  m_path[$];

  function automatic bit is_mem(int s);
    return s == S_FETCH || s == S_MEM_RD || s == S_MEM_WR;
  endfunction

  always @(posedge tb_clk) begin
    if (rst) begin
      m_state = S_FETCH;
      m_wait  = 0;
      m_fault = 1'b0;
      m_path.delete();
      m_valid = 1'b1;
    end else if (m_valid && m_state != S_HALT) begin
      if (is_mem(m_state) && !mem_ready) begin
        if (m_wait == TIMEOUT - 1) begin
          m_state = S_HALT;
          m_fault = 1'b1;
        end else m_wait++;
      end else begin
        if (m_state == S_DECODE) begin
          m_path.delete();
          if (opcode == OP_LDUR) m_path = '{S_MEM_ADDR, S_MEM_RD, S_LD_WB};
          else if (opcode == OP_STUR) m_path = '{S_MEM_ADDR, S_MEM_WR};
          else if (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_ORR}) m_path = '{S_R_EXEC, S_R_WB};
          else if (opcode ==? 11'b10110100???) m_path = '{S_CBZ};
          else if (opcode ==? 11'b000101?????) m_path = '{S_BRANCH};
        end
        if (m_state == S_DECODE && m_path.size() == 0) begin
          m_state = S_HALT;
          m_fault = 1'b1;
        end else if (m_state == S_FETCH) m_state = S_DECODE;
        else if (m_path.size() > 0) m_state = m_path.pop_front();
        else m_state = S_FETCH;
        m_wait = 0;
      end
    end
  end

  function automatic obs_t exp_obs();
    obs_t e = '0;
    e.state = 4'(m_state);
    e.fault = m_fault;
    case (m_state)
      S_FETCH:    begin e.mrd = 1; e.asb = 2'b01; e.irw = mem_ready; e.pcw = mem_ready; end
      S_DECODE:   begin e.asb = 2'b11; e.r2l = (opcode == OP_STUR) || (opcode ==? 11'b10110100???); end
      S_MEM_ADDR: begin e.asa = 1; e.asb = 2'b10; end
      S_MEM_RD:   begin e.iord = 1; e.mrd = 1; end
      S_LD_WB:    begin e.rgw = 1; e.m2r = 1; e.retire = 1; end
      S_MEM_WR:   begin e.iord = 1; e.mwr = 1; e.retire = mem_ready; end
      S_R_EXEC:   begin e.asa = 1; e.aluop = 2'b10; end
      S_R_WB:     begin e.rgw = 1; e.retire = 1; end
      S_CBZ:      begin e.asa = 1; e.aluop = 2'b01; e.pcsrc = 2'b10; e.pcw = zero; e.retire = 1; end
      S_BRANCH:   begin e.pcsrc = 2'b10; e.pcw = 1; e.retire = 1; end
      default:    ;
    endcase
    if (rst) begin
      e.pcw = 0; e.irw = 0; e.rgw = 0; e.mwr = 0; e.retire = 0;
    end
    return e;
  endfunction

  always @(negedge tb_clk) begin
    obs_t a;
    if (m_valid) begin
      a = {PCWrite, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc,
           ALUSrcA, PCSrc, ALUSrcB, ALUOp, retire, fault, state};
      check_output($sformatf("cycle@%0t", $time), {11'b0, a}, {11'b0, exp_obs()});
    end
  end

  task automatic next_cycle();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [10:0] op, input logic z);
    rst = 1'b1;
    mem_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    opcode = op;
    zero = z;
  endtask

  // st holds one 4-bit state per cycle, cycle 0 in the least significant nibble.
  task automatic run_seq(input string name, input logic [10:0] op, input logic z, input int n,
                         input logic [63:0] st, input logic [15:0] rdy,
                         input logic [15:0] ret, input logic [15:0] pcw);
    apply_stimulus(op, z);
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy[i];
      @(negedge tb_clk);
      check_output($sformatf("%s_state%0d", name, i), 32'(state), 32'(st[i*4 +: 4]));
      check_output($sformatf("%s_retire%0d", name, i), 32'(retire), 32'(ret[i]));
      check_output($sformatf("%s_pcwrite%0d", name, i), 32'(PCWrite), 32'(pcw[i]));
      next_cycle();
    end
  endtask

  initial begin
    int n_rd;

    rst = 1'b1;
    mem_ready = 1'b1;
    next_cycle();
    @(negedge tb_clk);
    check_output("rst_state", 32'(state), 32'(S_FETCH));
    check_output("rst_fault", 32'(fault), 32'd0);
    check_output("rst_irwrite", 32'(IRWrite), 32'd0);
    check_output("rst_pcwrite", 32'(PCWrite), 32'd0);

    run_seq("add",   OP_ADD, 1'b0, 5, 64'h07610, 16'h1F, 16'h08, 16'h11);
    run_seq("sub",   OP_SUB, 1'b0, 5, 64'h07610, 16'h1F, 16'h08, 16'h11);
    run_seq("and",   OP_AND, 1'b0, 5, 64'h07610, 16'h1F, 16'h08, 16'h11);
    run_seq("orr",   OP_ORR, 1'b0, 5, 64'h07610, 16'h1F, 16'h08, 16'h11);
    run_seq("ldur",  OP_LDUR, 1'b0, 9, 64'h043333210, 16'h1C7, 16'h080, 16'h101);
    run_seq("stur",  OP_STUR, 1'b0, 5, 64'h05210, 16'h1F, 16'h08, 16'h11);
    run_seq("cbz0",  11'b10110100000, 1'b0, 4, 64'h0810, 16'hF, 16'h4, 16'h9);
    run_seq("cbz1",  11'b10110100101, 1'b1, 4, 64'h0810, 16'hF, 16'h4, 16'hD);
    run_seq("b",     11'b00010111111, 1'b0, 4, 64'h0910, 16'hF, 16'h4, 16'hD);
    run_seq("illeg", 11'b00000000000, 1'b0, 5, 64'hAAA10, 16'h1F, 16'h00, 16'h01);
    @(negedge tb_clk);
    check_output("illeg_fault", 32'(fault), 32'd1);

    // Reset lands in the middle of a store that is still waiting on memory.
    run_seq("stwait", OP_STUR, 1'b0, 5, 64'h55210, 16'h07, 16'h00, 16'h01);
    rst = 1'b1;
    mem_ready = 1'b1;
    @(negedge tb_clk);
    check_output("stwait_rst_memwrite", 32'(MemWrite), 32'd0);
    check_output("stwait_rst_retire", 32'(retire), 32'd0);
    next_cycle();
    rst = 1'b0;
    mem_ready = 1'b0;
    @(negedge tb_clk);
    check_output("stwait_after_state", 32'(state), 32'(S_FETCH));
    check_output("stwait_after_memwrite", 32'(MemWrite), 32'd0);
    check_output("stwait_after_retire", 32'(retire), 32'd0);

    apply_stimulus(OP_ADD, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge tb_clk);
      check_output($sformatf("to_fetch_state%0d", i), 32'(state), 32'(S_FETCH));
      check_output($sformatf("to_fetch_irwrite%0d", i), 32'(IRWrite), 32'd0);
      next_cycle();
    end
    @(negedge tb_clk);
    check_output("to_halt_state", 32'(state), 32'(S_HALT));
    check_output("to_halt_fault", 32'(fault), 32'd1);
    next_cycle();
    mem_ready = 1'b1;
    @(negedge tb_clk);
    check_output("to_halt_sticky", 32'(state), 32'(S_HALT));
    check_output("to_halt_retire", 32'(retire), 32'd0);
    apply_stimulus(OP_ADD, 1'b0);
    @(negedge tb_clk);
    check_output("to_rst_state", 32'(state), 32'(S_FETCH));
    check_output("to_rst_fault", 32'(fault), 32'd0);

    // Ready on the last allowed cycle beats the timeout.
    apply_stimulus(OP_ADD, 1'b0);
    repeat (TIMEOUT - 1) next_cycle();
    mem_ready = 1'b1;
    @(negedge tb_clk);
    check_output("edge_irwrite", 32'(IRWrite), 32'd1);
    next_cycle();
    @(negedge tb_clk);
    check_output("edge_state", 32'(state), 32'(S_DECODE));
    check_output("edge_fault", 32'(fault), 32'd0);

    // A long fetch wait must not eat into the following load's wait budget.
    apply_stimulus(OP_LDUR, 1'b0);
    repeat (10) next_cycle();
    mem_ready = 1'b1;
    next_cycle();
    mem_ready = 1'b0;
    n_rd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge tb_clk);
      if (state == 4'(S_MEM_RD)) n_rd++;
      next_cycle();
    end
    check_output("rd_timeout_cycles", 32'(n_rd), 32'd16);
    check_output("rd_timeout_state", 32'(state), 32'(S_HALT));
    check_output("rd_timeout_fault", 32'(fault), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
